mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Load/store unit for the MEM stage, between the EX/MEM and MEM/WB registers.
//  Accepts one memory op from EX/MEM and runs it over a req/ack data-memory bus
//  with variable latency; memory is no longer assumed to respond in one cycle.
//  Holds the pipeline with 'stall' until the access completes.
//  Adds byte/half/word/dword access with sign/zero extension, misalignment
//  detection and a bus timeout.
// PARAMETERS
//  DATA_W   32  data bus width; 32 or 64 only
//  ADDR_W   32  byte address width
//  TIMEOUT  16  max cycles waiting for mem_ack; 0 = wait forever
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         synchronous reset, active-low (0 = reset)
//  ex_valid     in   1         EX/MEM holds a memory op this cycle
//  ex_read      in   1         load
//  ex_write     in   1         store; wins if ex_read is also 1
//  ex_size      in   2         0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only)
//  ex_unsigned  in   1         1 = zero-extend load, 0 = sign-extend
//  ex_addr      in   ADDR_W    byte address
//  ex_wdata     in   DATA_W    store data, LSB-justified
//  stall        out  1         freeze PC, IF/ID, ID/EX, EX/MEM
//  mem_req      out  1         bus request, registered
//  mem_we       out  1         1 = write
//  mem_addr     out  ADDR_W    bus-aligned address (low log2(DATA_W/8) bits = 0)
//  mem_wdata    out  DATA_W    store data shifted to its byte lane
//  mem_be       out  DATA_W/8  byte enables
//  mem_ack      in   1         one-cycle completion strobe
//  mem_rdata    in   DATA_W    read data, valid with mem_ack
//  wb_valid     out  1         one-cycle pulse: wb_rdata valid (loads only)
//  wb_rdata     out  DATA_W    aligned, extended load result
//  misalign     out  1         one-cycle pulse: op rejected
//  bus_err      out  1         one-cycle pulse: timeout
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE; all outputs 0; timeout counter 0.
//  FSM states: IDLE, BUSY, DONE.
//  start = ex_valid & (ex_read|ex_write) & aligned
//  aligned: size0 always; size1 addr[0]=0; size2 addr[1:0]=0;
//           size3 addr[2:0]=0 and DATA_W=64 (else misaligned).
//  IDLE:
//   - start -> BUSY; mem_req/we/addr/wdata/be registered at that edge.
//   - ex_valid & op & !aligned -> misalign=1 next cycle; no bus access; no
//     stall; stays IDLE.
//  BUSY: mem_req=1; all bus outputs stable until mem_ack.
//   - mem_ack -> DONE. Load data is captured: lane selected by the low
//     addr bits, then extended per ex_unsigned to DATA_W.
//   - count reaches TIMEOUT (TIMEOUT!=0) without ack -> DONE, bus_err=1.
//  DONE: mem_req=0; stall=0; wb_valid=1 for a load acked without error;
//        -> IDLE unconditionally (one cycle).
//  Pulse outputs: misalign, bus_err, wb_valid are registered, high 1 cycle.
//  stall = (IDLE & start) | BUSY  (combinational; DONE releases pipe).
//  Minimum op: start cycle N, req N+1, ack N+1, DONE/wb_valid N+2.
//  Stall is high for 2 cycles on a zero-wait access.
//  mem_be: byte 1<<lane; half 2'b11<<lane; word 4'hF<<lane; dword all ones.
//  mem_wdata: ex_wdata replicated across all lanes of the access size.
//  Edge cases:
//   - mem_ack outside BUSY: ignored.
//   - Ack in the same cycle as timeout: ack wins, bus_err=0.
//   - rst=0 mid-BUSY: mem_req=0 next cycle; a late ack is ignored.
//   - Store: DONE still occurs; wb_valid=0.
// TESTING
//  1 Zero-wait LW addr 0x10 (DATA_W=32), ack first cycle, rdata 0xDEADBEEF
//    -> mem_be=4'hF, wb_valid@N+2, wb_rdata=0xDEADBEEF, stall high 2 cycles.
//  2 LB signed addr 0x13, rdata 0x80xxxxxx, 3 wait cycles
//    -> mem_be=4'b1000, wb_rdata=0xFFFFFF80, stall held 5 cycles.
//    LBU same access -> wb_rdata=0x00000080.
//  3 SH addr 0x2, wdata 0x1234
//    -> mem_we=1, mem_be=4'b1100, mem_wdata=0x12341234, wb_valid stays 0.
//  4 LW addr 0x6
//    -> misalign pulse, mem_req never rises, stall 0.
//    LD on DATA_W=32 -> misalign.
//  5 TIMEOUT=4, no ack
//    -> bus_err after 4 BUSY cycles, then IDLE, wb_valid 0.
//    Then ack arriving after that -> ignored.
//  6 rst=0 during BUSY
//    -> next cycle all outputs 0, state IDLE.
//    New LW after reset completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and data memory (slave).
// Variable-latency req/ack handshake with byte enables.
interface mem_stage_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one EX/MEM memory op over a variable-latency
// req/ack bus, stalling the pipe until done; handles size, extension, alignment, timeout.
module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_read,
  input  logic              ex_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              stall,
  mem_stage_lsu_if.master   bus,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              misalign,
  output logic              bus_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              op, aligned, start, timed_out;
  logic [OFF_W-1:0]  lane;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        size_q;
  logic              uns_q, load_q;
  logic [OFF_W-1:0]  lane_q;
  logic [DATA_W-1:0] shifted, mask, load_ext;
  logic              sign;

  assign op    = ex_read | ex_write;
  assign lane  = ex_addr[OFF_W-1:0];
  assign start = ex_valid & op & aligned;

  always_comb begin
    aligned = 1'b0;
    unique case (ex_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~ex_addr[0];
      2'd2:    aligned = (ex_addr[1:0] == 2'b00);
      default: aligned = (DATA_W == 64) && (ex_addr[2:0] == 3'b000);
    endcase
  end

  // Store data is replicated into every lane so the byte enables alone pick the target bytes.
  always_comb begin
    be_d    = '0;
    wdata_d = '0;
    unique case (ex_size)
      2'd0: begin
        be_d    = BE_W'(1) << lane;
        wdata_d = {BE_W{ex_wdata[7:0]}};
      end
      2'd1: begin
        be_d    = BE_W'(2'b11) << lane;
        wdata_d = {(DATA_W/16){ex_wdata[15:0]}};
      end
      2'd2: begin
        be_d    = BE_W'(4'hF) << lane;
        wdata_d = {(DATA_W/32){ex_wdata[31:0]}};
      end
      default: begin
        be_d    = '1;
        wdata_d = ex_wdata;
      end
    endcase
  end

  // Load path: shift the addressed lane down, then sign- or zero-fill above the access size.
  always_comb begin
    shifted = bus.mem_rdata >> {lane_q, 3'b000};
    mask    = '1;
    sign    = 1'b0;
    unique case (size_q)
      2'd0:    begin mask = DATA_W'(8'hFF);          sign = shifted[7];  end
      2'd1:    begin mask = DATA_W'(16'hFFFF);       sign = shifted[15]; end
      2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF);  sign = shifted[31]; end
      default: begin mask = '1;                      sign = 1'b0;        end
    endcase
    load_ext = (sign & ~uns_q) ? (shifted | ~mask) : (shifted & mask);
  end

  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (bus.mem_ack || timed_out) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign stall = ((state_q == IDLE) && start) || (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      load_q        <= 1'b0;
      lane_q        <= '0;
      wb_valid      <= 1'b0;
      wb_rdata      <= '0;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      state_q  <= state_d;
      misalign <= (state_q == IDLE) && ex_valid && op && !aligned;
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= ex_write;
            bus.mem_addr  <= {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus.mem_wdata <= wdata_d;
            bus.mem_be    <= be_d;
            size_q        <= ex_size;
            uns_q         <= ex_unsigned;
            load_q        <= ~ex_write;
            lane_q        <= lane;
            cnt_q         <= '0;
          end
        end
        BUSY: begin
          // An ack landing on the timeout cycle still completes the access normally.
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (load_q) begin
              wb_valid <= 1'b1;
              wb_rdata <= load_ext;
            end
          end else if (timed_out) begin
            bus.mem_req <= 1'b0;
            bus_err     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
